// File: rtl/bs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bs_pkg
// Purpose : Shared constants and types for the bit-serial arithmetic blocks.
// Revision: 1.0 - initial release
// ============================================================================
package bs_pkg;

  localparam int BS_W = 16;

  typedef logic [$clog2(BS_W)-1:0] bs_idx_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } bs_state_e;

endpackage : bs_pkg
`default_nettype wire

// File: rtl/bs_mac_lane.sv
`default_nettype none
// ============================================================================
// Module  : bs_mac_lane
// Purpose : One bit-serial multiply-accumulate lane (operands, partial sum, A).
// Revision: 1.0 - initial release
// ============================================================================
module bs_mac_lane
  import bs_pkg::*;
#(
  parameter int W  = BS_W,
  parameter int KW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic          start_i,
  input  logic          done_i,
  input  logic          acc_sel_i,
  input  logic [KW-1:0] idx_i,
  input  logic          x_i,
  input  logic          y_i,
  output logic          p_o
);

  logic [W-1:0] xr_q, yr_q, s_q, r_q, a_q;
  logic         p_q;

  logic [W-1:0] onehot_w, xr_b_w, yr_b_w, s_b_w, xv_w, yv_w, sum_w;
  logic         a_bit_w;

  // S is aligned so bit 0 carries weight k; carries past weight W-1 are dropped.
  always_comb begin
    onehot_w = {{(W-1){1'b0}}, 1'b1} << idx_i;
    xr_b_w   = start_i ? '0 : xr_q;
    yr_b_w   = start_i ? '0 : yr_q;
    s_b_w    = start_i ? '0 : s_q;
    xv_w     = xr_b_w | (x_i ? onehot_w : '0);
    yv_w     = yr_b_w | (y_i ? onehot_w : '0);
    a_bit_w  = acc_sel_i & a_q[idx_i];
    sum_w    = s_b_w + (x_i ? yv_w : '0) + (y_i ? xr_b_w : '0)
             + {{(W-1){1'b0}}, a_bit_w};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xr_q <= '0;
      yr_q <= '0;
      s_q  <= '0;
      r_q  <= '0;
      a_q  <= '0;
      p_q  <= 1'b0;
    end else begin
      p_q <= valid_i & sum_w[0];
      if (valid_i) begin
        xr_q <= xv_w;
        yr_q <= yv_w;
        s_q  <= {1'b0, sum_w[W-1:1]};
        r_q  <= {sum_w[0], r_q[W-1:1]};
        // A only changes on a completed word, so an aborted word leaves it intact.
        if (done_i) begin
          a_q <= {sum_w[0], r_q[W-1:1]};
        end
      end
    end
  end

  assign p_o = p_q;

endmodule : bs_mac_lane
`default_nettype wire

// File: rtl/bs_mac.sv
`default_nettype none
// ============================================================================
// Module  : bs_mac
// Purpose : CH-lane bit-serial multiply-accumulate array with shared framing.
// Revision: 1.0 - initial release
// ============================================================================
module bs_mac
  import bs_pkg::*;
#(
  parameter int W  = BS_W,
  parameter int CH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          firstbit,
  input  logic          lastbit,
  input  logic          acc_en,
  input  logic [CH-1:0] x,
  input  logic [CH-1:0] y,
  output logic [CH-1:0] p,
  output logic          p_first,
  output logic          p_last
);

  localparam int KW = $clog2(W);

  bs_state_e     state_q;
  logic [KW-1:0] cnt_q;
  logic          acc_sel_q;
  logic          p_first_q;
  logic          p_last_q;

  logic          valid_w;
  logic          done_w;
  logic          acc_sel_w;
  logic [KW-1:0] idx_w;

  // Completion is positional (k reaches W-1), so lastbit carries no extra information.
  logic          unused_lastbit;
  assign unused_lastbit = lastbit;

  always_comb begin
    valid_w   = firstbit | (state_q == ST_RUN);
    idx_w     = firstbit ? '0 : cnt_q;
    done_w    = (state_q == ST_RUN) && !firstbit && (cnt_q == KW'(W-1));
    acc_sel_w = firstbit ? acc_en : acc_sel_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_sel_q <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
    end else begin
      p_first_q <= firstbit;
      p_last_q  <= done_w;
      if (firstbit) begin
        state_q   <= ST_RUN;
        cnt_q     <= KW'(1);
        acc_sel_q <= acc_en;
      end else if (state_q == ST_RUN) begin
        if (cnt_q == KW'(W-1)) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + KW'(1);
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < CH; i++) begin : g_lane
      bs_mac_lane #(
        .W  (W),
        .KW (KW)
      ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_w),
        .start_i   (firstbit),
        .done_i    (done_w),
        .acc_sel_i (acc_sel_w),
        .idx_i     (idx_w),
        .x_i       (x[i]),
        .y_i       (y[i]),
        .p_o       (p[i])
      );
    end
  endgenerate

  assign p_first = p_first_q;
  assign p_last  = p_last_q;

endmodule : bs_mac
`default_nettype wire
